// File: rtl/video_fetch_resp.sv
// DRAM slot responder: hands each DRAM cycle slot to video or CPU, follows each
// access through a read-latency tag pipe, and buffers video words in a FWFT FIFO.
module video_fetch_resp #(
  parameter int CYCLE_LEN  = 4,
  parameter int RD_LAT     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] video_addr,
  output logic        video_next,
  input  logic        video_go,
  input  logic [1:0]  video_bw,
  input  logic        vid_flush,
  output logic [15:0] vid_data,
  output logic        vid_rdy,
  input  logic        vid_pop,
  input  logic        cpu_req,
  input  logic [20:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [15:0] cpu_wrdata,
  output logic        cpu_next,
  output logic        cpu_strobe,
  output logic [15:0] cpu_rddata,
  output logic        dram_req,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [15:0] dram_wrdata,
  input  logic [15:0] dram_rddata
);
  localparam int CW = $clog2(CYCLE_LEN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = 5;

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_RD, TAG_WR} tag_e;

  logic [CW-1:0] ccnt;
  logic [1:0]    scnt;
  logic          cend;
  logic          slot_ok;
  logic          credit_ok;
  logic          video_elig;
  tag_e          tag_pipe [RD_LAT];
  tag_e          exit_tag;
  logic [SW-1:0] vid_inflight;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;
  logic          fifo_push;
  logic          fifo_pop;

  always_comb begin
    vid_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (tag_pipe[i] == TAG_VID) vid_inflight = vid_inflight + SW'(1);
    end
  end

  always_comb begin
    slot_ok = 1'b1;
    case (video_bw)
      2'd0:    slot_ok = (scnt == 2'd0);
      2'd1:    slot_ok = ~scnt[0];
      default: slot_ok = 1'b1;
    endcase
  end

  // Strobes: video_next / cpu_next are single-clock accept pulses on the cend
  // clock; the requester must hold address/data stable until it sees its pulse.
  assign cend       = (ccnt == CW'(CYCLE_LEN - 1));
  assign credit_ok  = (SW'(fifo_count) + vid_inflight) < SW'(FIFO_DEPTH);
  assign video_elig = video_go & slot_ok & credit_ok & ~vid_flush;
  assign video_next = cend & video_elig;
  assign cpu_next   = cend & ~video_elig & cpu_req;

  assign exit_tag  = tag_pipe[RD_LAT-1];
  assign fifo_push = (exit_tag == TAG_VID) && !vid_flush;
  assign fifo_pop  = vid_pop && vid_rdy;
  assign vid_rdy   = (fifo_count != '0);
  assign vid_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccnt        <= '0;
      scnt        <= '0;
      dram_req    <= 1'b0;
      dram_rnw    <= 1'b1;
      dram_addr   <= '0;
      dram_wrdata <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      cpu_strobe  <= 1'b0;
      cpu_rddata  <= '0;
    end else begin
      ccnt <= cend ? '0 : ccnt + CW'(1);
      if (cend) scnt <= scnt + 2'd1;

      if (video_next) begin
        dram_addr <= video_addr;
        dram_rnw  <= 1'b1;
        dram_req  <= 1'b1;
      end else if (cpu_next) begin
        dram_addr   <= cpu_addr;
        dram_rnw    <= cpu_rnw;
        dram_wrdata <= cpu_wrdata;
        dram_req    <= 1'b1;
      end else if (cend) begin
        dram_req <= 1'b0;
      end

      // A flush retires video reads still travelling; CPU tags are untouched.
      tag_pipe[0] <= video_next ? TAG_VID : (cpu_next ? (cpu_rnw ? TAG_RD : TAG_WR) : TAG_NONE);
      for (int i = 1; i < RD_LAT; i++) begin
        tag_pipe[i] <= (vid_flush && tag_pipe[i-1] == TAG_VID) ? TAG_NONE : tag_pipe[i-1];
      end

      cpu_strobe <= (exit_tag == TAG_RD) || (exit_tag == TAG_WR);
      if (exit_tag == TAG_RD) cpu_rddata <= dram_rddata;

      if (vid_flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
        if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({fifo_push, fifo_pop})
          2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
          2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= dram_rddata;
  end

endmodule
